conv_psum_bank_ctrl: RTL
========================

CONV_PSUM_BANK_CTRL -- requirements
Module: conv_psum_bank_ctrl

Interface
REQ-001 SHALL have parameter LANES, default 24, meaning activated outputs per row.
REQ-002 SHALL have parameter DW, default 8, meaning bits per activated output.
REQ-003 SHALL have parameter CH, default 4, meaning output channels (filters), CH >= 2.
REQ-004 SHALL have parameter ROWS, default 32, meaning rows per channel per frame, ROWS >= 2.
REQ-005 SHALL have port clk, input, 1, the clock; rst_n, input, 1, the reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1, meaning a write row is offered.
REQ-007 SHALL have port in_ready, output, 1, meaning the write row is accepted this cycle.
REQ-008 SHALL have port in_ch, input, clog2(CH), meaning the destination channel.
REQ-009 SHALL have port in_data, input, LANES*DW, meaning the row; lane 0 is in the MSBs.
REQ-010 SHALL have port out_valid, input-side paired with out_ready (input, 1); out_valid is an output of width 1.
REQ-011 SHALL have port out_data, output, CH*LANES*DW, meaning one row of all channels; channel 0 is in the MSBs.
REQ-012 SHALL have port out_row, output, clog2(ROWS), meaning the row index of out_data.
REQ-013 SHALL have ports frame_done (output, 1, a one-cycle pulse after the last row drains) and err_ovf (output, 1, a sticky overflow flag).

Function
REQ-014 SHALL run an FSM with states FILL, DRAIN and FLUSH; the reset state is FILL.
REQ-015 In FILL, in_ready=1; each accepted row SHALL write at address wr_cnt[in_ch], then wr_cnt[in_ch] increments.
REQ-016 A write to a channel whose wr_cnt equals ROWS SHALL be dropped, set err_ovf, and leave the storage unchanged.
REQ-017 When every wr_cnt equals ROWS, the FSM SHALL move to DRAIN on the next cycle; the final write of the frame counts toward the transition.
REQ-018 Channels SHALL fill in any interleaved order; partial frames SHALL wait in FILL indefinitely.
REQ-019 Storage SHALL use synchronous read with 1-cycle latency; out_valid SHALL rise 1 cycle after entering DRAIN, with out_row=0.
REQ-020 Handshake: out_data and out_row SHALL hold stable while out_valid && !out_ready; a row advances only on out_valid && out_ready.
REQ-021 With out_ready held at 1, one row SHALL be emitted per cycle without bubbles; rows SHALL be emitted 0..ROWS-1 in order.
REQ-022 After row ROWS-1 is accepted, the block SHALL enter FLUSH for 1 cycle: it pulses frame_done, clears all wr_cnt, drops out_valid, and returns to FILL.
REQ-023 While in DRAIN or FLUSH, in_ready SHALL be 0, unless CONV_BUF_PINGPONG_EN is defined.
REQ-024 A simultaneous in_valid with the FILL->DRAIN transition cycle SHALL be accepted only if it was counted before the transition; no write SHALL be lost or duplicated.

Reset
REQ-025 Asserting rst_n low at any time, including mid-DRAIN, SHALL force FILL, all wr_cnt=0, out_valid=0, out_row=0, out_data=0, frame_done=0, err_ovf=0, and in_ready=0 while reset is asserted.
REQ-026 in_ready SHALL rise 1 cycle after reset release; storage contents need not be cleared.
REQ-027 err_ovf SHALL clear only on reset.

Configuration
REQ-028 If CONV_BUF_PINGPONG_EN is defined, the block SHALL use two storage banks: FILL writes bank A while DRAIN reads bank B.
REQ-029 With ping-pong, in_ready stays 1 during DRAIN; the banks swap when the fill completes and the drain is idle.
REQ-030 With ping-pong, a completed fill SHALL stall (in_ready=0) until the current drain finishes.
REQ-031 Without CONV_BUF_PINGPONG_EN, the block SHALL have a single bank and the behaviour in REQ-023.

Verification
REQ-032 Write CH=4 x 32 rows in round-robin with data=f(ch,row) and out_ready=1 -> 32 consecutive out_valid beats, out_row 0..31, each beat equal to concatenated f(0..3,row), and frame_done 1 cycle after the last beat.
REQ-033 Fill, then toggle out_ready 1/0 every cycle -> no beat dropped or repeated, and data stable while stalled.
REQ-034 Send a 33rd write to ch2 mid-fill -> err_ovf=1, row 31 of ch2 unchanged, and the frame still completes normally.
REQ-035 Assert rst_n low at drain row 10 -> all outputs 0 next edge; a new full frame then drains correctly from row 0.
REQ-036 Fill ch0-2 fully and ch3 with 31 rows -> no out_valid; the 32nd ch3 write -> out_valid 2 cycles later.
REQ-037 With CONV_BUF_PINGPONG_EN, write frame 2 during frame 1's drain -> in_ready=1 throughout, and frame 2 drains immediately after frame 1's frame_done.

Source files
------------

// File: rtl/conv_psum_bank_ctrl.sv
// Partial-sum row buffer between a convolution engine and its consumer.
// Rows arrive per channel in any interleaving; once every channel holds ROWS
// rows, the frame drains one row per beat with all channels side by side.
// Optional build macro CONV_BUF_PINGPONG_EN adds a second bank so the next
// frame can fill while the current one drains.
//
// state | meaning
// FILL  | accepting writes (ping-pong: drain side idle)
// DRAIN | streaming rows 0..ROWS-1 from the read bank
// FLUSH | one cycle: frame_done pulse, fill counters recycled
module conv_psum_bank_ctrl #(
  parameter int LANES = 24,
  parameter int DW    = 8,
  parameter int CH    = 4,
  parameter int ROWS  = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [$clog2(CH)-1:0]       in_ch,
  input  logic [LANES*DW-1:0]         in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CH*LANES*DW-1:0]      out_data,
  output logic [$clog2(ROWS)-1:0]     out_row,
  output logic                        frame_done,
  output logic                        err_ovf
);

  localparam int RW  = LANES * DW;
  localparam int CW  = $clog2(CH);
  localparam int RAW = $clog2(ROWS);
  localparam int WCW = $clog2(ROWS + 1);
`ifdef CONV_BUF_PINGPONG_EN
  localparam int NB  = 2;
`else
  localparam int NB  = 1;
`endif

  typedef enum logic [1:0] {FILL, DRAIN, FLUSH} state_t;

  state_t           state_q, state_d;
  logic             rdy_en_q;
  logic [WCW-1:0]   wr_cnt_q [CH];
  logic [RAW-1:0]   rd_ptr_q;
  logic [RW-1:0]    mem [NB][CH][ROWS];

  logic wr_fire, ch_ok, ch_full, wr_en, wr_drop;
  logic all_full_nxt, fill_complete, go_drain, clr_cnt;
  logic rd_load, last_beat;
  logic wr_bank, rd_bank;

  assign wr_fire   = in_valid && in_ready;
  assign ch_ok     = (32'(in_ch) < CH);
  assign ch_full   = ch_ok && (wr_cnt_q[in_ch] == WCW'(ROWS));
  assign wr_en     = wr_fire && ch_ok && !ch_full;
  assign wr_drop   = wr_fire && !wr_en;
  assign last_beat = out_valid && out_ready && (out_row == RAW'(ROWS - 1));
  assign frame_done = (state_q == FLUSH);

  // Frame is complete once every channel is full, counting a write landing this cycle.
  always_comb begin
    all_full_nxt = 1'b1;
    for (int c = 0; c < CH; c++) begin
      if ((wr_cnt_q[c] != WCW'(ROWS)) &&
          !(wr_en && (in_ch == CW'(c)) && (wr_cnt_q[c] == WCW'(ROWS - 1))))
        all_full_nxt = 1'b0;
    end
  end

`ifdef CONV_BUF_PINGPONG_EN
  logic fill_done_q, wr_bank_q, rd_bank_q;

  assign fill_complete = fill_done_q || all_full_nxt;
  assign in_ready      = rdy_en_q && !fill_done_q;
  assign clr_cnt       = go_drain;
  assign wr_bank       = wr_bank_q;
  assign rd_bank       = rd_bank_q;

  // Completed fill parks here until the drain side can take the bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_done_q <= 1'b0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
    end else if (go_drain) begin
      fill_done_q <= 1'b0;
      rd_bank_q   <= wr_bank_q;
      wr_bank_q   <= ~wr_bank_q;
    end else if (all_full_nxt) begin
      fill_done_q <= 1'b1;
    end
  end
`else
  assign fill_complete = all_full_nxt;
  assign in_ready      = rdy_en_q && (state_q == FILL);
  assign clr_cnt       = (state_q == FLUSH);
  assign wr_bank       = 1'b0;
  assign rd_bank       = 1'b0;
`endif

  // State register; rdy_en holds in_ready low for the first cycle after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FILL;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
    end
  end

  // Next state; a read is issued on DRAIN entry and on every non-final accepted beat.
  always_comb begin
    state_d  = state_q;
    go_drain = 1'b0;
    rd_load  = 1'b0;
    unique case (state_q)
      FILL: begin
        if (fill_complete) begin
          state_d  = DRAIN;
          go_drain = 1'b1;
        end
      end
      DRAIN: begin
        rd_load = !out_valid || (out_ready && (out_row != RAW'(ROWS - 1)));
        if (last_beat) state_d = FLUSH;
      end
      FLUSH: begin
`ifdef CONV_BUF_PINGPONG_EN
        if (fill_complete) begin
          state_d  = DRAIN;
          go_drain = 1'b1;
        end else begin
          state_d = FILL;
        end
`else
        state_d = FILL;
`endif
      end
      default: state_d = FILL;
    endcase
  end

  // Per-channel fill counters; a counter at ROWS rejects further writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) wr_cnt_q[c] <= '0;
    end else if (clr_cnt) begin
      for (int c = 0; c < CH; c++) wr_cnt_q[c] <= '0;
    end else if (wr_en) begin
      wr_cnt_q[in_ch] <= wr_cnt_q[in_ch] + WCW'(1);
    end
  end

  // Sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_ovf <= 1'b0;
    else if (wr_drop) err_ovf <= 1'b1;
  end

  // Row storage write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][in_ch][wr_cnt_q[in_ch][RAW-1:0]] <= in_data;
  end

  // Read pointer runs one row ahead of out_row while draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        rd_ptr_q <= '0;
    else if (go_drain) rd_ptr_q <= '0;
    else if (rd_load)  rd_ptr_q <= rd_ptr_q + RAW'(1);
  end

  // Registered read port doubles as the output holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_row   <= '0;
      out_valid <= 1'b0;
    end else if (rd_load) begin
      for (int c = 0; c < CH; c++)
        out_data[(CH-1-c)*RW +: RW] <= mem[rd_bank][c][rd_ptr_q];
      out_row   <= rd_ptr_q;
      out_valid <= 1'b1;
    end else if (last_beat) begin
      out_valid <= 1'b0;
    end
  end

endmodule
